// File: rtl/seg7_display.sv
// ----------------------------------------------------------------------------
// seg7_display
//   Memory-mapped output peripheral for an 8-digit, common-anode 7-segment
//   display. The CPU writes 32 bits of hex data and an 8-bit digit-enable mask
//   over the IO bus. A free-running scan counter time-multiplexes the digits,
//   and each nibble is decoded to active-low segments.
//
// Parameters
//   SCAN_DIV   clock cycles each digit stays lit before the scan advances (>= 2)
//
// Ports
//   clock       in   1   system clock, rising-edge active
//   reset       in   1   asynchronous, active-high reset
//   SegCtrl     in   1   chip select from the IO address decoder
//   ioWrite     in   1   bus write strobe (write when SegCtrl && ioWrite)
//   seg_addr    in   2   0=data[15:0], 1=data[31:16], 2=mask[7:0], 3=reserved
//   write_data  in   16  bus write data ([7:0] only for the mask)
//   write_ack   out  1   one-cycle pulse after every accepted write
//   seg_out     out  8   active-low segments, bit0=a .. bit6=g, bit7=dp
//   seg_en      out  8   active-low digit enables, bit i = digit i
//
// Configuration
//   SEG_BLANK_LEADING_ZERO_EN  when defined, digits above the most significant
//                              non-zero nibble are blanked (digit 0 never is).
// ----------------------------------------------------------------------------
module seg7_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SegCtrl,
  input  logic        ioWrite,
  input  logic [1:0]  seg_addr,
  input  logic [15:0] write_data,
  output logic        write_ack,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en
);

  localparam int             CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Hex nibble to active-low {g..a}; dp stays off (bit7 = 1).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  logic [31:0]      data_r;
  logic [7:0]       mask_r;
  logic [2:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       seg_out_r;
  logic [7:0]       seg_en_r;
  logic             write_ack_r;

  logic             wr_en_s;
  logic             scan_wrap_s;
  logic [3:0]       nibble_s;
  logic             lz_blank_s;
  logic             shown_s;
  logic [7:0]       seg_out_nxt_s;
  logic [7:0]       seg_en_nxt_s;

  // Bus decode, scan wrap detection and next-cycle display values.
  always_comb begin
    wr_en_s     = SegCtrl && ioWrite;
    scan_wrap_s = (cnt_r == CNT_MAX);
    nibble_s    = data_r[{idx_r, 2'b00} +: 4];
`ifdef SEG_BLANK_LEADING_ZERO_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    if (idx_r != 3'd0) begin
      lz_blank_s = ((data_r >> {idx_r, 2'b00}) == 32'd0);
    end else begin
      lz_blank_s = 1'b0;
    end
`else
    lz_blank_s  = 1'b0;
`endif
    shown_s = mask_r[idx_r] && !lz_blank_s;
    if (shown_s) begin
      seg_en_nxt_s  = ~(8'd1 << idx_r);
      seg_out_nxt_s = hex_to_seg(nibble_s);
    end else begin
      seg_en_nxt_s  = 8'hFF;
      seg_out_nxt_s = 8'hFF;
    end
  end

  // Register file: data halves and mask; address 3 is acknowledged but inert.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r <= 32'h0000_0000;
      mask_r <= 8'hFF;
    end else if (wr_en_s) begin
      case (seg_addr)
        2'd0:    data_r[15:0]  <= write_data;
        2'd1:    data_r[31:16] <= write_data;
        2'd2:    mask_r        <= write_data[7:0];
        default: ;
      endcase
    end else begin
      data_r <= data_r;
      mask_r <= mask_r;
    end
  end

  // Free-running scan: count 0..SCAN_DIV-1, advance digit index on wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
      idx_r <= 3'd0;
    end else if (scan_wrap_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Registered outputs, built from the pre-edge index, data and mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_out_r   <= 8'hFF;
      seg_en_r    <= 8'hFF;
      write_ack_r <= 1'b0;
    end else begin
      seg_out_r   <= seg_out_nxt_s;
      seg_en_r    <= seg_en_nxt_s;
      write_ack_r <= wr_en_s;
    end
  end

  assign seg_out   = seg_out_r;
  assign seg_en    = seg_en_r;
  assign write_ack = write_ack_r;

endmodule
